// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// pulse_stretcher
//
// Purpose:
//    Converts single-cycle event strobes into clean output levels that stay
//    high for exactly HOLD_CYCLES clock cycles. This is the inverse of a
//    level-to-pulse converter. Event sources such as keypad strobes or timer
//    ticks feed it, and slow consumers such as LEDs, a buzzer or a lock
//    actuator read its output.
//
//    Strobes that arrive while a level is already being driven are handled
//    in one of two ways:
//       - RETRIGGER = 0: the strobe is queued, up to MAX_PENDING entries.
//       - RETRIGGER = 1: the strobe restarts the hold timer.
//    Each queued level is separated from the previous one by GAP_CYCLES low
//    cycles. When GAP_CYCLES is 0, queued levels run back to back with no
//    low cycle between them.
//
// Parameters:
//    HOLD_CYCLES  clock cycles the level stays high per accepted pulse (>=1)
//    GAP_CYCLES   low cycles forced between queued levels (>=0)
//    MAX_PENDING  maximum number of queued pulses (>=1)
//    RETRIGGER    1: a pulse during HOLD restarts the timer; 0: it is queued
//
// Ports:
//    clk             in   system clock, rising edge
//    reset           in   asynchronous, active-low (0 = reset)
//    enable          in   1: accept new pulses; 0: ignore pulse_in
//    pulse_in        in   event strobe, sampled on each clock edge
//    clear_overflow  in   clears the sticky overflow flag
//    level_out       out  stretched level (registered)
//    busy            out  1 while the state machine is not idle
//    pending         out  number of queued pulses
//    overflow        out  sticky flag: a pulse was dropped because the
//                         queue was full
// ---------------------------------------------------------------------------
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 10,
   parameter int GAP_CYCLES  = 1,
   parameter int MAX_PENDING = 3,
   parameter bit RETRIGGER   = 1'b0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               pulse_in,
   input  logic                               clear_overflow,
   output logic                               level_out,
   output logic                               busy,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
   output logic                               overflow
);

   // The timer must be wide enough to hold the larger of the two reload
   // values. The floor of 2 keeps the width at one bit or more even when
   // both HOLD_CYCLES and GAP_CYCLES are 1.
   localparam int HG_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW     = $clog2((HG_MAX > 2) ? HG_MAX : 2);
   localparam int PW     = $clog2(MAX_PENDING + 1);

   // The GAP reload is never used when GAP_CYCLES is 0. Clamping it to 0
   // keeps the constant from going negative.
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [PW-1:0]    pending_q, pending_d;
   logic             overflow_q, overflow_d;
   logic             level_q, level_d;
   logic             busy_q, busy_d;

   logic             accept;
   logic             queueReq;
   logic             pendDec;
   logic [PW-1:0]    pendAvail;
   logic             ovfSet;

   // Next-state logic for the sequencer.
   //
   // A queued pulse is consumed when HOLD ends. That is the moment pending
   // decrements, whether the machine goes to GAP next or, with
   // GAP_CYCLES == 0, straight back into HOLD. The GAP -> HOLD transition
   // only reloads the timer; it does not touch pending.
   //
   // With RETRIGGER set, a pulse during HOLD reloads the timer. This takes
   // priority over the normal end-of-hold decision, so a pulse on the last
   // HOLD cycle keeps the level high instead of letting it drop.
   always_comb begin
      accept   = pulse_in & enable;
      state_d  = state_q;
      timer_d  = timer_q;
      queueReq = 1'b0;
      pendDec  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = HOLD;
               timer_d = HOLD_LOAD;
            end
         end

         HOLD: begin
            if (RETRIGGER && accept) begin
               timer_d = HOLD_LOAD;
            end else begin
               queueReq = accept;
               if (timer_q == '0) begin
                  if (pending_q != '0) begin
                     pendDec = 1'b1;
                     if (GAP_CYCLES == 0) begin
                        state_d = HOLD;
                        timer_d = HOLD_LOAD;
                     end else begin
                        state_d = GAP;
                        timer_d = GAP_LOAD;
                     end
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
         end

         GAP: begin
            queueReq = accept;
            if (timer_q == '0) begin
               state_d = HOLD;
               timer_d = HOLD_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end

         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Queue bookkeeping.
   //
   // Any decrement in this cycle is applied first. The incoming pulse is
   // then judged against the remaining room in the queue. A pulse that
   // coincides with a HOLD exit therefore leaves pending unchanged, and a
   // pulse is dropped only if the queue is still full after that exit.
   //
   // When a set and a clear of overflow land in the same cycle, the set
   // wins, so a drop that coincides with a clear is never lost.
   always_comb begin
      pendAvail  = pending_q - PW'(pendDec);
      ovfSet     = queueReq && (pendAvail == PEND_MAX);
      pending_d  = pendAvail;
      if (queueReq && !ovfSet) begin
         pending_d = pendAvail + PW'(1);
      end
      overflow_d = ovfSet | (overflow_q & ~clear_overflow);
      level_d    = (state_d == HOLD);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers.
   //
   // The outputs are derived from the next state, so level_out and busy
   // line up with the registered state. An asynchronous reset clears
   // everything at once and abandons any level or queue that is in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         level_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         level_q    <= level_d;
         busy_q     <= busy_d;
      end
   end

   assign level_out = level_q;
   assign busy      = busy_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Directed bench for pulse_stretcher. Three instances share one set of
// input stimulus:
//    dutA : HOLD=10, GAP=1, MAX_PENDING=3, RETRIGGER=0 (queueing)
//    dutR : HOLD=10, GAP=1, MAX_PENDING=3, RETRIGGER=1 (retrigger)
//    dutZ : HOLD=10, GAP=0, MAX_PENDING=3, RETRIGGER=0 (back-to-back levels)
//
// Cycle n means the interval just after the n-th rising clock edge counted
// from the start of a scenario. A pulse driven during cycle n is sampled at
// the edge that opens cycle n+1.
// ---------------------------------------------------------------------------
module tb_pulse_stretcher;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       pulseIn;
   logic       clearOvf;

   logic       levelA, busyA, ovfA;
   logic [1:0] pendA;
   logic       levelR, busyR, ovfR;
   logic [1:0] pendR;
   logic       levelZ, busyZ, ovfZ;
   logic [1:0] pendZ;

   int errors = 0;
   int checks = 0;

   pulse_stretcher #(.HOLD_CYCLES(10), .GAP_CYCLES(1), .MAX_PENDING(3), .RETRIGGER(1'b0)) dutA (
      .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulseIn),
      .clear_overflow(clearOvf), .level_out(levelA), .busy(busyA),
      .pending(pendA), .overflow(ovfA)
   );

   pulse_stretcher #(.HOLD_CYCLES(10), .GAP_CYCLES(1), .MAX_PENDING(3), .RETRIGGER(1'b1)) dutR (
      .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulseIn),
      .clear_overflow(clearOvf), .level_out(levelR), .busy(busyR),
      .pending(pendR), .overflow(ovfR)
   );

   pulse_stretcher #(.HOLD_CYCLES(10), .GAP_CYCLES(0), .MAX_PENDING(3), .RETRIGGER(1'b0)) dutZ (
      .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulseIn),
      .clear_overflow(clearOvf), .level_out(levelZ), .busy(busyZ),
      .pending(pendZ), .overflow(ovfZ)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to the next cycle and sample 1 unit after the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against the expected value and record the
   // result.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hold reset for two edges, then release it just after an edge.
   // The cycle in which the release happens is cycle 0 of the next scenario.
   task automatic applyReset();
      pulseIn  = 1'b0;
      clearOvf = 1'b0;
      enable   = 1'b1;
      reset    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b1;
   endtask

   // Directed scenarios, run in sequence.
   initial begin
      reset    = 1'b0;
      enable   = 1'b1;
      pulseIn  = 1'b0;
      clearOvf = 1'b0;

      // Power-on reset values.
      #12;
      checkOutput("rst.level",    levelA, 0);
      checkOutput("rst.busy",     busyA,  0);
      checkOutput("rst.pending",  pendA,  0);
      checkOutput("rst.overflow", ovfA,   0);

      // Single pulse: level high in cycles 1..10, idle again in cycle 11.
      applyReset();
      pulseIn = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         applyStimulus();
         pulseIn = 1'b0;
         checkOutput($sformatf("t2.level@%0d", c), levelA, (c <= 10) ? 1 : 0);
         if (c == 11) checkOutput("t2.busy@11", busyA, 0);
      end

      // Queueing: pulses in cycles 0, 3 and 5 give levels in cycles 1-10,
      // 12-21 and 23-32.
      applyReset();
      pulseIn = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         applyStimulus();
         pulseIn = (c == 3) || (c == 5);
         checkOutput($sformatf("t3.level@%0d", c), levelA,
                     ((c >= 1 && c <= 10) || (c >= 12 && c <= 21) || (c >= 23 && c <= 32)) ? 1 : 0);
         if (c == 4)  checkOutput("t3.pending@4",  pendA, 1);
         if (c == 6)  checkOutput("t3.pending@6",  pendA, 2);
         if (c == 11) checkOutput("t3.pending@11", pendA, 1);
         if (c == 22) checkOutput("t3.pending@22", pendA, 0);
         if (c == 33) checkOutput("t3.busy@33",    busyA, 0);
      end

      // Overflow: queue saturates at 3. A drop in the same cycle as a clear
      // leaves overflow set; a clear on its own then resets it.
      applyReset();
      pulseIn = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         applyStimulus();
         pulseIn  = (c <= 6);
         clearOvf = (c == 6) || (c == 7);
         if (c == 4) checkOutput("t4.pending@4",  pendA, 3);
         if (c == 4) checkOutput("t4.overflow@4", ovfA,  0);
         if (c == 5) checkOutput("t4.overflow@5", ovfA,  1);
         if (c == 6) checkOutput("t4.pending@6",  pendA, 3);
         if (c == 7) checkOutput("t4.ovfSetWins", ovfA,  1);
         if (c == 8) checkOutput("t4.ovfCleared", ovfA,  0);
         if (c == 8) checkOutput("t4.pending@8",  pendA, 3);
      end
      pulseIn  = 1'b0;
      clearOvf = 1'b0;

      // Retrigger: a pulse on the last HOLD cycle (cycle 10) keeps the level
      // high through cycle 20.
      applyReset();
      pulseIn = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         applyStimulus();
         pulseIn = (c == 10);
         checkOutput($sformatf("t5.level@%0d", c), levelR, (c <= 20) ? 1 : 0);
         if (c == 11 || c == 20) checkOutput($sformatf("t5.pending@%0d", c), pendR, 0);
         if (c == 21) checkOutput("t5.busy@21", busyR, 0);
      end

      // Enable gating: a disabled pulse in IDLE does nothing. Disabling
      // during HOLD still lets the already-queued level run.
      applyReset();
      enable  = 1'b0;
      pulseIn = 1'b1;
      applyStimulus();
      checkOutput("t6.idleBusy",  busyA,  0);
      checkOutput("t6.idleLevel", levelA, 0);
      applyStimulus();
      checkOutput("t6.idlePending", pendA, 0);
      checkOutput("t6.idleOvf",     ovfA,  0);
      enable  = 1'b1;
      pulseIn = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         applyStimulus();
         enable  = (c < 4);
         pulseIn = (c == 3) || (c >= 4 && c <= 9);
         checkOutput($sformatf("t6.level@%0d", c), levelA,
                     ((c >= 1 && c <= 10) || (c >= 12 && c <= 21)) ? 1 : 0);
         if (c == 4)  checkOutput("t6.pending@4",   pendA, 1);
         if (c == 10) checkOutput("t6.pending@10",  pendA, 1);
         if (c == 10) checkOutput("t6.overflow@10", ovfA,  0);
         if (c == 11) checkOutput("t6.pending@11",  pendA, 0);
         if (c == 22) checkOutput("t6.busy@22",     busyA, 0);
      end
      enable  = 1'b1;
      pulseIn = 1'b0;

      // Zero gap: one queued pulse makes the level continuous for 20 cycles.
      applyReset();
      pulseIn = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         applyStimulus();
         pulseIn = (c == 2);
         checkOutput($sformatf("tz.level@%0d", c), levelZ, (c <= 20) ? 1 : 0);
         if (c == 3)  checkOutput("tz.pending@3",  pendZ, 1);
         if (c == 11) checkOutput("tz.pending@11", pendZ, 0);
         if (c == 21) checkOutput("tz.busy@21",    busyZ, 0);
      end

      // Asynchronous reset mid-HOLD with two pulses queued clears every
      // output before the next clock edge.
      applyReset();
      pulseIn = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         applyStimulus();
         pulseIn = (c <= 2);
      end
      checkOutput("t1.prePending", pendA,  2);
      checkOutput("t1.preLevel",   levelA, 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("t1.level",    levelA, 0);
      checkOutput("t1.busy",     busyA,  0);
      checkOutput("t1.pending",  pendA,  0);
      checkOutput("t1.overflow", ovfA,   0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
